if_id_queue: RTL and testbench

- Decoupling buffer between the IF stage and the ID stage. It accepts fetched {pc, pc_plus4, instr} triples from IF and presents them in order to ID.
- Absorbs ID stalls without freezing the PC, and discards all buffered instructions on a taken branch or jump (pc_src redirect).
- Small synchronous FIFO with valid/ready handshakes on both sides and a flush port.

---
 rtl/if_id_queue_pkg.sv | 14 +
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 95 +++++++++
 tb/tb_if_id_queue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID definitions: datapath width, the NOP word shown
// by an empty queue, and the fetch packet the ID stage consumes.
package if_id_queue_pkg;

  localparam int          PKG_XLEN = 32;
  localparam logic [31:0] PKG_NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc_plus4;
    logic [PKG_XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and
// one asynchronous read port. Ports: clk, we/waddr/wdata, raddr/rdata.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3 * PKG_XLEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling FIFO with valid/ready on both sides and flush.
// Ports: clk, rst, in_* (IF side), flush, out_* (ID side), count.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          XLEN      = PKG_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(PKG_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_pc_plus4,
  input  logic [XLEN-1:0]            in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = 3 * XLEN;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          empty, full;
  logic          push, pop;
  logic [W-1:0]  head;

  assign empty = (wptr_q == rptr_q);
  // same slot, different lap: writer is a full lap ahead
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                 (wptr_q[AW] != rptr_q[AW]);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign count = CW'(wptr_q - rptr_q);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      // drop everything by catching the reader up to the writer
      rptr_d = wptr_q;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata ({in_pc, in_pc_plus4, in_instr}),
    .raddr (rptr_q[AW-1:0]),
    .rdata (head)
  );

  always_comb begin
    out_pc       = '0;
    out_pc_plus4 = '0;
    out_instr    = NOP_INSTR;
    if (!empty) begin
      out_pc       = head[W-1 -: XLEN];
      out_pc_plus4 = head[2*XLEN-1 -: XLEN];
      out_instr    = head[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table plus
// scoreboard-backed sequences for flush, full and reset corners.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush;
  logic        out_valid, out_ready;
  logic [31:0] in_pc, in_pc_plus4, in_instr;
  logic [31:0] out_pc, out_pc_plus4, out_instr;
  logic [2:0]  count;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_pc_plus4  (in_pc_plus4),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr),
    .count        (count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return {pc[15:0], 16'h0233};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // One clock: drive, check against the model, advance the model.
  task automatic cyc(bit r, bit fl, bit iv, logic [31:0] pc, bit ordy);
    bit eir, eov;
    @(posedge clk);
    #1;
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_pc_plus4 = pc + 32'd4; in_instr = instr_of(pc);
    #1;
    eir = (sb.size() < DEPTH) && !fl;
    eov = (sb.size() > 0) && !fl;
    chk("in_ready", {31'd0, in_ready}, {31'd0, eir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
    chk("count", {29'd0, count}, sb.size());
    if (sb.size() > 0) begin
      chk("head_pc", out_pc, sb[0]);
      chk("head_pc4", out_pc_plus4, sb[0] + 32'd4);
      chk("head_instr", out_instr, instr_of(sb[0]));
    end else begin
      chk("empty_pc", out_pc, 32'd0);
      chk("empty_instr", out_instr, NOP);
    end
    if (r || fl) begin
      sb.delete();
    end else begin
      if (eov && ordy) void'(sb.pop_front());
      if (eir && iv) sb.push_back(pc);
    end
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    bit          ordy;
    int          ecnt;
    bit          eov;
    bit          eir;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1, 32'h00, 0, 0, 0, 1};
    vt[1] = '{1, 32'h04, 0, 1, 1, 1};
    vt[2] = '{1, 32'h08, 0, 2, 1, 1};
    vt[3] = '{1, 32'h0C, 0, 3, 1, 1};
    vt[4] = '{1, 32'h10, 0, 4, 1, 0};
    vt[5] = '{0, 32'h10, 1, 4, 1, 0};
    vt[6] = '{0, 32'h00, 1, 3, 1, 1};
    vt[7] = '{0, 32'h00, 1, 2, 1, 1};
    vt[8] = '{0, 32'h00, 1, 1, 1, 1};
    vt[9] = '{0, 32'h00, 1, 0, 0, 1};

    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = 0; in_pc_plus4 = 4; in_instr = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_cnt", {29'd0, count}, 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd0);

    // fill to full, held fifth push, then drain in order
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, vt[i].iv, vt[i].pc, vt[i].ordy);
      chk("vec_cnt", {29'd0, count}, vt[i].ecnt);
      chk("vec_ov", {31'd0, out_valid}, {31'd0, vt[i].eov});
      chk("vec_ir", {31'd0, in_ready}, {31'd0, vt[i].eir});
    end

    // streaming at occupancy 2 across pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 32'(i * 4), i >= 2);
      if (i >= 2) chk("stream_cnt", {29'd0, count}, 32'd2);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // flush with push and pop requested in the same cycle
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h100 + 32'(i * 4), 0);
    cyc(0, 1, 1, 32'h40, 1);
    chk("flush_ir", {31'd0, in_ready}, 32'd0);
    chk("flush_ov", {31'd0, out_valid}, 32'd0);
    cyc(0, 0, 1, 32'h80, 0);
    chk("post_flush_cnt", {29'd0, count}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("post_flush_head", out_pc, 32'h80);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("dbl_flush_cnt", {29'd0, count}, 32'd0);

    // full: pop allowed, push refused in the same cycle
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h200 + 32'(i * 4), 0);
    cyc(0, 0, 1, 32'h300, 1);
    chk("full_ir", {31'd0, in_ready}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("full_pop_cnt", {29'd0, count}, 32'd3);
    chk("full_pop_ir", {31'd0, in_ready}, 32'd1);
    chk("full_pop_head", out_pc, 32'h204);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    // reset beats flush mid-stream
    cyc(0, 0, 1, 32'h500, 0);
    cyc(0, 0, 1, 32'h504, 0);
    cyc(1, 1, 1, 32'h508, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_mid_cnt", {29'd0, count}, 32'd0);
    chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
    cyc(0, 0, 1, 32'h600, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_head", out_pc, 32'h600);
    cyc(0, 0, 0, 0, 0);
    chk("rst_mid_empty", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
